// File: rtl/dmem_arb_pkg.sv
// Shared types and helpers for the data-memory arbiter (CPU port vs. DMA/debug port).
package dmem_arb_pkg;

  localparam int DW       = 32;
  localparam int BEW      = DW / 8;
  localparam int ADDR_MAX = 32;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DMA = 1'b1
  } owner_e;

  // Address field is sized for the widest supported memory; ports use the low AW bits.
  typedef struct packed {
    logic                we;
    logic [ADDR_MAX-1:0] addr;
    logic [DW-1:0]       wdata;
    logic [BEW-1:0]      be;
  } mem_req_t;

  function automatic mem_req_t gate_req(input mem_req_t req, input logic en);
    return en ? req : '0;
  endfunction

endpackage

// File: rtl/dmem_arb_starve_ctr.sv
// Saturating DMA wait counter: raises o_force once the DMA port has waited MAX_WAIT cycles.
module dmem_arb_starve_ctr #(
  parameter int MAX_WAIT = 4
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_req,
  input  logic i_gnt,
  output logic o_force
);

  localparam int            CW  = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] SAT = CW'(MAX_WAIT);

  logic [CW-1:0] r_cnt;

  // Counts only consecutive losing cycles; any grant or dropped request restarts the wait.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_cnt <= '0;
    end else if (!i_req || i_gnt) begin
      r_cnt <= '0;
    end else if (r_cnt != SAT) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_force = (r_cnt == SAT);

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data memory arbiter between the CPU load/store port and the DMA/debug port.
// Default: fixed CPU priority with a starvation guard; define DMEM_ARB_RR_EN for round-robin.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int AW       = 8,
  parameter int MAX_WAIT = 4
) (
  input  logic           i_clk,
  input  logic           i_reset,
  input  logic           i_cpu_req,
  input  logic           i_cpu_we,
  input  logic [AW-1:0]  i_cpu_addr,
  input  logic [DW-1:0]  i_cpu_wdata,
  input  logic [BEW-1:0] i_cpu_be,
  output logic           o_cpu_gnt,
  output logic           o_cpu_rvalid,
  output logic [DW-1:0]  o_cpu_rdata,
  input  logic           i_dma_req,
  input  logic           i_dma_we,
  input  logic [AW-1:0]  i_dma_addr,
  input  logic [DW-1:0]  i_dma_wdata,
  input  logic [BEW-1:0] i_dma_be,
  output logic           o_dma_gnt,
  output logic           o_dma_rvalid,
  output logic [DW-1:0]  o_dma_rdata,
  output logic           o_mem_en,
  output logic           o_mem_we,
  output logic [AW-1:0]  o_mem_addr,
  output logic [DW-1:0]  o_mem_wdata,
  output logic [BEW-1:0] o_mem_be,
  input  logic [DW-1:0]  i_mem_rdata
);

  mem_req_t w_cpu_req;
  mem_req_t w_dma_req;
  mem_req_t w_win_req;
  logic     w_cpu_win;
  logic     w_dma_win;
  logic     w_dma_first;
  logic     w_rsp_live;
  logic     w_unused_addr;
  logic     r_rd_pend;
  owner_e   r_rd_owner;

  always_comb begin
    w_cpu_req                = '0;
    w_cpu_req.we             = i_cpu_we;
    w_cpu_req.addr[AW-1:0]   = i_cpu_addr;
    w_cpu_req.wdata          = i_cpu_wdata;
    w_cpu_req.be             = i_cpu_be;
    w_dma_req                = '0;
    w_dma_req.we             = i_dma_we;
    w_dma_req.addr[AW-1:0]   = i_dma_addr;
    w_dma_req.wdata          = i_dma_wdata;
    w_dma_req.be             = i_dma_be;
  end

`ifdef DMEM_ARB_RR_EN
  owner_e r_last_gnt;

  // On contention the port that did not win most recently goes first.
  assign w_dma_first = (r_last_gnt == OWN_CPU);

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_last_gnt <= OWN_DMA;
    end else if (w_cpu_win) begin
      r_last_gnt <= OWN_CPU;
    end else if (w_dma_win) begin
      r_last_gnt <= OWN_DMA;
    end
  end
`else
  dmem_arb_starve_ctr #(
    .MAX_WAIT (MAX_WAIT)
  ) u_starve_ctr (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_req   (i_dma_req),
    .i_gnt   (w_dma_win),
    .o_force (w_dma_first)
  );
`endif

  assign w_cpu_win = i_reset && i_cpu_req && !(i_dma_req && w_dma_first);
  assign w_dma_win = i_reset && i_dma_req && (!i_cpu_req || w_dma_first);

  assign o_cpu_gnt = w_cpu_win;
  assign o_dma_gnt = w_dma_win;

  assign w_win_req     = gate_req(w_dma_win ? w_dma_req : w_cpu_req, w_cpu_win || w_dma_win);
  assign w_unused_addr = ^w_win_req.addr;

  assign o_mem_en    = w_cpu_win || w_dma_win;
  assign o_mem_we    = w_win_req.we;
  assign o_mem_addr  = w_win_req.addr[AW-1:0];
  assign o_mem_wdata = w_win_req.wdata;
  assign o_mem_be    = w_win_req.be;

  // Remember who issued a read so the next-cycle memory data returns to that port only.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_rd_pend  <= 1'b0;
      r_rd_owner <= OWN_CPU;
    end else begin
      r_rd_pend  <= o_mem_en && !o_mem_we;
      r_rd_owner <= w_dma_win ? OWN_DMA : OWN_CPU;
    end
  end

  assign w_rsp_live   = i_reset && r_rd_pend;
  assign o_cpu_rvalid = w_rsp_live && (r_rd_owner == OWN_CPU);
  assign o_dma_rvalid = w_rsp_live && (r_rd_owner == OWN_DMA);
  assign o_cpu_rdata  = o_cpu_rvalid ? i_mem_rdata : '0;
  assign o_dma_rdata  = o_dma_rvalid ? i_mem_rdata : '0;

  a_one_grant  : assert property (@(posedge i_clk) !(o_cpu_gnt && o_dma_gnt));
  a_one_rvalid : assert property (@(posedge i_clk) !(o_cpu_rvalid && o_dma_rvalid));
  a_en_match   : assert property (@(posedge i_clk) o_mem_en == (o_cpu_gnt || o_dma_gnt));

endmodule
